// File: rtl/npu_pkg.sv
// Shared NPU definitions used by the instruction queue and the controller.
package npu_pkg;

  localparam int INST_WIDTH    = 256;
  localparam int DRAM_ADDR_BIT = 32;
  localparam int DIMENTION_BIT = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_GEMM  = 4'd3,
    OP_CONV  = 4'd4,
    OP_ACT   = 4'd5,
    OP_SYNC  = 4'd6
  } operation_t;

  typedef enum logic [1:0] {
    MEM_DRAM = 2'd0,
    MEM_WBUF = 2'd1,
    MEM_IBUF = 2'd2,
    MEM_OBUF = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    STG_FETCH   = 2'd0,
    STG_COMPUTE = 2'd1,
    STG_WRITE   = 2'd2,
    STG_DONE    = 2'd3
  } stage_t;

  typedef struct packed {
    logic [7:0] flags;
    logic [7:0] shift;
  } config_t;

  // Everything that is not a named field is reserved padding up to INST_WIDTH.
  localparam int INST_USED_BIT = 4 + 2 + 2 + 2 + 16 + 2 * DRAM_ADDR_BIT + 3 * DIMENTION_BIT;
  localparam int INST_RSVD_BIT = INST_WIDTH - INST_USED_BIT;

  typedef struct packed {
    logic [INST_RSVD_BIT-1:0] reserved;
    logic [DIMENTION_BIT-1:0] dim_k;
    logic [DIMENTION_BIT-1:0] dim_n;
    logic [DIMENTION_BIT-1:0] dim_m;
    logic [DRAM_ADDR_BIT-1:0] dst_addr;
    logic [DRAM_ADDR_BIT-1:0] src_addr;
    config_t                  cfg;
    stage_t                   stage;
    mem_type_t                dst_mem;
    mem_type_t                src_mem;
    operation_t               op;
  } instruction_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module sync_fifo #(
  parameter  int WIDTH = 256,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push & ~w_full & ~i_flush;
  assign w_do_pop  = i_pop & (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage is data only; stale entries are never visible because the output is gated by valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_queue.sv
// Host word assembler feeding a FWFT instruction FIFO toward the controller.
// Optional build macro INST_QUEUE_WATERMARK_EN adds the queue_peak occupancy watermark output.
module instruction_queue #(
  parameter  int INST_WIDTH = npu_pkg::INST_WIDTH,
  parameter  int WORD_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int WORDS      = INST_WIDTH / WORD_WIDTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_wvalid,
  input  logic [WORD_WIDTH-1:0] host_wdata,
  input  logic                  host_wlast,
  output logic                  host_wready,
  input  logic                  host_flush,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  input  logic                  instruction_ready,
  output logic [CNT_W-1:0]      queue_count,
  output logic                  frame_err
`ifdef INST_QUEUE_WATERMARK_EN
  ,
  output logic [CNT_W-1:0]      queue_peak
`endif
);

  import npu_pkg::*;

  localparam int              BEAT_W    = $clog2(WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_DROP    = 2'd2
  } asm_st_t;

  asm_st_t                r_state;
  asm_st_t                w_state_nxt;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [BEAT_W-1:0]      w_beat_nxt;
  logic [WORD_WIDTH-1:0]  r_buf [WORDS-1];
  logic                   r_frame_err;
  logic                   w_acc;
  logic                   w_store;
  logic                   w_push;
  logic                   w_err_set;
  logic                   w_pop;
  logic [INST_WIDTH-1:0]  w_push_data;

  // Back-pressure only blocks the final word of a frame when the FIFO is full, so it depends
  // on registered state alone and never on instruction_ready.
  assign host_wready = (r_state != ASM_COLLECT) | (r_beat_cnt != LAST_BEAT) |
                       (queue_count < CNT_W'(DEPTH));
  assign w_acc       = host_wvalid & host_wready;
  assign w_pop       = instruction_valid & instruction_ready;

  // Assembler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ASM_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  // Assembler next-state: framing checks, word storage and push decision; flush wins.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_store     = 1'b0;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    if (host_flush) begin
      w_state_nxt = ASM_IDLE;
      w_beat_nxt  = '0;
    end else if (w_acc) begin
      case (r_state)
        ASM_IDLE: begin
          w_store = 1'b1;
          if (host_wlast) begin
            w_err_set = 1'b1;
          end else begin
            w_state_nxt = ASM_COLLECT;
            w_beat_nxt  = BEAT_W'(1);
          end
        end
        ASM_COLLECT: begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_nxt = '0;
            if (host_wlast) begin
              w_push      = 1'b1;
              w_state_nxt = ASM_IDLE;
            end else begin
              w_err_set   = 1'b1;
              w_state_nxt = ASM_DROP;
            end
          end else begin
            w_store = 1'b1;
            if (host_wlast) begin
              w_err_set   = 1'b1;
              w_state_nxt = ASM_IDLE;
              w_beat_nxt  = '0;
            end else begin
              w_beat_nxt = r_beat_cnt + BEAT_W'(1);
            end
          end
        end
        ASM_DROP: begin
          if (host_wlast) w_state_nxt = ASM_IDLE;
        end
        default: begin
          w_state_nxt = ASM_IDLE;
          w_beat_nxt  = '0;
        end
      endcase
    end
  end

  // Capture words 0..WORDS-2; the last word bypasses straight into the FIFO push.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_beat_cnt] <= host_wdata;
  end

  // Word 0 lands in the low bits, the final word in the high bits.
  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < WORDS - 1; i++) begin
      w_push_data[i*WORD_WIDTH +: WORD_WIDTH] = r_buf[i];
    end
    w_push_data[(WORDS-1)*WORD_WIDTH +: WORD_WIDTH] = host_wdata;
  end

  // Sticky framing error, cleared only by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_frame_err <= 1'b0;
    else if (host_flush) r_frame_err <= 1'b0;
    else if (w_err_set)  r_frame_err <= 1'b1;
  end

  assign frame_err = r_frame_err;

  sync_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (host_flush),
    .o_data      (instruction),
    .o_valid     (instruction_valid),
    .o_count     (queue_count)
  );

`ifdef INST_QUEUE_WATERMARK_EN
  logic [CNT_W-1:0] r_peak;

  // Highest occupancy seen since reset or flush, lagging queue_count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_peak <= '0;
    else if (host_flush)          r_peak <= '0;
    else if (queue_count > r_peak) r_peak <= queue_count;
  end

  assign queue_peak = r_peak;
`endif

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
Host-side producer of the 256-bit instruction stream consumed by the controller.
- Accepts 32-bit words from the host over a valid/ready word interface.
- Assembles 8 words into one instruction, with framing checked via host_wlast.
- Buffers complete instructions in a DEPTH-entry FIFO.
- Drives instruction/instruction_valid toward the controller and honours instruction_ready.

Parameters:
INST_WIDTH, 256, instruction width in bits; must be a multiple of WORD_WIDTH.
WORD_WIDTH, 32, host word width in bits.
DEPTH, 16, FIFO entries; power of two, at least 2.
WORDS (local), INST_WIDTH/WORD_WIDTH = 8, words per instruction.
CNT_W (local), $clog2(DEPTH+1), occupancy counter width.

Ports:
clk  in  1  single clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
host_wvalid  in  1  host word valid.
host_wdata  in  WORD_WIDTH  host word; word 0 maps to instruction bits [31:0], word 7 to [255:224].
host_wlast  in  1  marks the final word of an instruction.
host_wready  out  1  queue accepts the current word.
host_flush  in  1  single-cycle pulse; discards partial and queued instructions.
instruction  out  INST_WIDTH  head-of-queue instruction.
instruction_valid  out  1  queue non-empty.
instruction_ready  in  1  controller accepts the head entry.
queue_count  out  CNT_W  number of stored instructions.
frame_err  out  1  sticky framing-error flag.

Behaviour:
- Reset (asynchronous, active-high):
  - Assembler state goes to ASM_IDLE, beat_cnt=0, FIFO pointers=0.
  - Outputs: instruction_valid=0, instruction=0, queue_count=0, frame_err=0, host_wready=1.
- Handshakes:
  - Word accepted when host_wvalid & host_wready.
  - Pop when instruction_valid & instruction_ready.
  - instruction and instruction_valid are stable while valid=1 and ready=0.
- host_wready = (state!=ASM_COLLECT) | (beat_cnt!=WORDS-1) | (queue_count<DEPTH).
  - Purely registered inputs; no combinational path from instruction_ready.
  - A push when full is therefore never accepted, even if a pop occurs in the same cycle.
- Assembler FSM:
  - ASM_IDLE: an accepted word is stored at slot 0 and beat_cnt becomes 1.
    - If host_wlast=1 on that word: frame error, discard, stay in ASM_IDLE.
    - Otherwise go to ASM_COLLECT.
  - ASM_COLLECT: each accepted word is stored at slot beat_cnt, then beat_cnt increments.
    - wlast=1 with beat_cnt<WORDS-1: discard, set frame_err, go to ASM_IDLE, beat_cnt=0.
    - beat_cnt==WORDS-1 with wlast=1: push the assembled instruction, go to ASM_IDLE.
    - beat_cnt==WORDS-1 with wlast=0: discard, set frame_err, go to ASM_DROP.
  - ASM_DROP: host_wready=1; words are discarded until one is accepted with wlast=1, then go to ASM_IDLE.
- FIFO (first-word-fall-through):
  - A push at edge t makes instruction_valid=1 immediately after edge t when the FIFO was empty, i.e. 1 cycle after the last word is accepted.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: queue_count unchanged, head advances.
  - Pop when empty cannot occur because valid=0.
- Flush (host_flush=1):
  - Priority over push in the same cycle; the word on host_wdata that cycle is dropped.
  - A pop in the same cycle completes, because the controller captured it.
  - All remaining entries are cleared, the assembler returns to ASM_IDLE with beat_cnt=0, and frame_err clears.
  - instruction_valid=0 the next cycle.
- frame_err is set by any framing error and cleared only by reset or flush.

Optional Feature:
INST_QUEUE_WATERMARK_EN
- Defined: adds output queue_peak [CNT_W]. It holds the maximum queue_count reached since reset or flush, is updated one cycle after queue_count changes, and is reset to 0.
- Undefined: no queue_peak port and no related logic.

Decomposition:
- Shared package npu_pkg holds:
  - operation_t, mem_type_t, config_t, stage_t and instruction_t, shared with the controller.
  - DRAM_ADDR_BIT and DIMENTION_BIT.
  - INST_WIDTH=256.
- The assembler FSM enum asm_st_t is local to this module.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, count output), reusable elsewhere.

Test Plan:
- Reset, then 8 words 0x00000001..0x00000008 with wlast on word 8, controller ready=0 → instruction_valid=1 one cycle after word 8; instruction[31:0]=1, [255:224]=8; queue_count=1.
- Push 16 instructions with ready=0 → queue_count=16, host_wready=0 on the 8th word of the 17th instruction; set ready=1 for 1 cycle → count 15 and that word is accepted next cycle.
- wlast on word 3 → no push, frame_err=1, next 8-word frame pushed correctly. wlast=0 on word 8 → 3 extra words dropped until wlast, queue_count unchanged.
- Queue holding 2 entries, ready=1, host_flush pulsed on the same cycle → head consumed, queue_count=0 next cycle, frame_err=0, beat_cnt=0.
- Continuous push and pop at DEPTH-1 occupancy for 40 instructions → count constant, pointers wrap, data order preserved (scoreboard).
- Assert reset mid-frame at word 5 → all outputs at reset values immediately; next full frame is assembled from word 0. With WATERMARK_EN: queue_peak=16 after the fill test.
